// File: rtl/uart_cmd_decoder_if.sv
// Decoded host-command outputs of uart_cmd_decoder: line enables, delay-tap writes,
// integration period and per-command accept/reject pulses.
interface uart_cmd_decoder_if #(
    parameter int unsigned DW = 10
);
    logic [31:0]   active_line;
    logic          delay_wr;
    logic [3:0]    delay_index;
    logic [DW-1:0] delay_value;
    logic [31:0]   integration_time;
    logic          cmd_done;
    logic          cmd_error;

    modport master (
        output active_line,
        output delay_wr,
        output delay_index,
        output delay_value,
        output integration_time,
        output cmd_done,
        output cmd_error
    );

    modport slave (
        input active_line,
        input delay_wr,
        input delay_index,
        input delay_value,
        input integration_time,
        input cmd_done,
        input cmd_error
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Host command receiver: 8N1 UART deserializer plus command-frame parser.
// Define CMD_TIMEOUT_EN to abandon a partial command after TIMEOUT_BYTES idle byte-times.
module uart_cmd_decoder #(
    parameter int unsigned CLK_FREQUENCY = 400000000,
    parameter int unsigned BAUD_RATE     = 57600,
    parameter int unsigned NUM_INPUTS    = 12,
    parameter int unsigned MAX_DELAY     = 1024,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RX,
    uart_cmd_decoder_if.master cmd
);
    localparam int unsigned DW   = $clog2(MAX_DELAY);
    localparam int unsigned CPB  = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF = CPB / 2;

    if (NUM_INPUTS < 1 || NUM_INPUTS > 16 || TIMEOUT_BYTES < 1) begin : g_bad_params
        $error("uart_cmd_decoder: NUM_INPUTS must be 1..16 and TIMEOUT_BYTES at least 1");
    end

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;
    typedef enum logic [1:0] {PIdle, PArg, PExec} p_state_e;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic        rx_meta_q, rx_sync_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        byte_valid;
    logic        frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                // Mid start bit: a high line means the falling edge was a glitch.
                if (rx_cnt_q == HALF - 1) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 32'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == CPB - 1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 32'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == CPB - 1) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        frame_err  = 1'b1;
                        rx_state_d = RxWaitHigh;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 32'd1;
                end
            end
            RxWaitHigh: begin
                if (rx_sync_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Parser and command execution
    // ------------------------------------------------------------------
    p_state_e      p_state_q, p_state_d;
    logic [3:0]    op_q, op_d;
    logic [3:0]    idx_q, idx_d;
    logic [31:0]   arg_q, arg_d;
    logic [2:0]    arg_cnt_q, arg_cnt_d;
    logic [2:0]    arg_len_q, arg_len_d;

    logic [31:0]   active_line_q, active_line_d;
    logic          delay_wr_q, delay_wr_d;
    logic [3:0]    delay_index_q, delay_index_d;
    logic [DW-1:0] delay_value_q, delay_value_d;
    logic [31:0]   integ_q, integ_d;
    logic          cmd_done_q, cmd_done_d;
    logic          cmd_error_q, cmd_error_d;

    logic          exec;
    logic [3:0]    exec_op;
    logic [3:0]    exec_idx;
    logic [31:0]   exec_arg;
    logic          idx_ok;
    logic [31:0]   dly_sat;
    logic          done;
    logic          err;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = TIMEOUT_BYTES * 10 * CPB;
    logic [31:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_state_q     <= PIdle;
            op_q          <= '0;
            idx_q         <= '0;
            arg_q         <= '0;
            arg_cnt_q     <= '0;
            arg_len_q     <= '0;
            active_line_q <= '0;
            delay_wr_q    <= 1'b0;
            delay_index_q <= '0;
            delay_value_q <= '0;
            integ_q       <= CLK_FREQUENCY;
            cmd_done_q    <= 1'b0;
            cmd_error_q   <= 1'b0;
        end else begin
            p_state_q     <= p_state_d;
            op_q          <= op_d;
            idx_q         <= idx_d;
            arg_q         <= arg_d;
            arg_cnt_q     <= arg_cnt_d;
            arg_len_q     <= arg_len_d;
            active_line_q <= active_line_d;
            delay_wr_q    <= delay_wr_d;
            delay_index_q <= delay_index_d;
            delay_value_q <= delay_value_d;
            integ_q       <= integ_d;
            cmd_done_q    <= cmd_done_d;
            cmd_error_q   <= cmd_error_d;
        end
    end

    always_comb begin
        p_state_d     = p_state_q;
        op_d          = op_q;
        idx_d         = idx_q;
        arg_d         = arg_q;
        arg_cnt_d     = arg_cnt_q;
        arg_len_d     = arg_len_q;
        active_line_d = active_line_q;
        delay_wr_d    = 1'b0;
        delay_index_d = delay_index_q;
        delay_value_d = delay_value_q;
        integ_d       = integ_q;
        exec          = 1'b0;
        exec_op       = op_q;
        exec_idx      = idx_q;
        exec_arg      = arg_q;
        idx_ok        = 1'b0;
        dly_sat       = '0;
        done          = 1'b0;
        err           = 1'b0;
`ifdef CMD_TIMEOUT_EN
        to_cnt_d      = '0;
`endif

        case (p_state_q)
            PIdle: begin
                if (byte_valid) begin
                    case (rx_shift_q[3:0])
                        4'h0, 4'h1: begin
                            exec     = 1'b1;
                            exec_op  = rx_shift_q[3:0];
                            exec_idx = rx_shift_q[7:4];
                            exec_arg = '0;
                        end
                        4'h2, 4'h3: begin
                            p_state_d = PArg;
                            op_d      = rx_shift_q[3:0];
                            idx_d     = rx_shift_q[7:4];
                            arg_d     = '0;
                            arg_cnt_d = '0;
                            arg_len_d = rx_shift_q[0] ? 3'd4 : 3'd2;
                        end
                        default: err = 1'b1;
                    endcase
                end
            end
            PArg: begin
                if (byte_valid) begin
                    // Payload arrives LSB first; byte n lands in bits [8n+7:8n].
                    arg_d[{arg_cnt_q[1:0], 3'b000} +: 8] = rx_shift_q;
                    arg_cnt_d = arg_cnt_q + 3'd1;
                    if (arg_cnt_q == arg_len_q - 3'd1) begin
                        exec     = 1'b1;
                        exec_arg = arg_d;
                    end
                end
`ifdef CMD_TIMEOUT_EN
                else if (to_cnt_q == TimeoutCycles - 1) begin
                    p_state_d = PIdle;
                    err       = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
`endif
            end
            PExec: p_state_d = PIdle;
            default: p_state_d = PIdle;
        endcase

        // Effects are registered on the edge into PExec so they coincide with that cycle.
        if (exec) begin
            p_state_d = PExec;
            idx_ok    = ({1'b0, exec_idx} < 5'(NUM_INPUTS));
            case (exec_op)
                4'h0: begin
                    if (idx_ok) begin
                        active_line_d[exec_idx] = 1'b1;
                        done = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                4'h1: begin
                    if (idx_ok) begin
                        active_line_d[exec_idx] = 1'b0;
                        done = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                4'h2: begin
                    if ({16'd0, exec_arg[15:0]} >= MAX_DELAY) begin
                        dly_sat = MAX_DELAY - 1;
                    end else begin
                        dly_sat = {16'd0, exec_arg[15:0]};
                    end
                    if (idx_ok) begin
                        delay_wr_d    = 1'b1;
                        delay_index_d = exec_idx;
                        delay_value_d = dly_sat[DW-1:0];
                        done = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                4'h3: begin
                    if (exec_arg != 32'd0) begin
                        integ_d = exec_arg;
                        done = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: err = 1'b1;
            endcase
        end

        if (frame_err) begin
            p_state_d = PIdle;
            err       = 1'b1;
        end

        cmd_done_d  = done & ~err;
        cmd_error_d = err;
    end

    assign cmd.active_line      = active_line_q;
    assign cmd.delay_wr         = delay_wr_q;
    assign cmd.delay_index      = delay_index_q;
    assign cmd.delay_value      = delay_value_q;
    assign cmd.integration_time = integ_q;
    assign cmd.cmd_done         = cmd_done_q;
    assign cmd.cmd_error        = cmd_error_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: table vectors, hand-written corner sequences and
// randomized commands scored against a behavioural command model.
module tb_uart_cmd_decoder;
    localparam int unsigned ClkFreq = 1000000;
    localparam int unsigned Baud    = 62500;
    localparam int unsigned Cpb     = 16;
    localparam int unsigned NumIn   = 12;
    localparam int unsigned MaxDly  = 1024;
    localparam int unsigned Dw      = 10;

    logic clk = 1'b0;
    logic reset;
    logic RX;

    always #5 clk = ~clk;

    uart_cmd_decoder_if #(.DW(Dw)) cmd_if ();

    uart_cmd_decoder #(
        .CLK_FREQUENCY(ClkFreq),
        .BAUD_RATE    (Baud),
        .NUM_INPUTS   (NumIn),
        .MAX_DELAY    (MaxDly),
        .TIMEOUT_BYTES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .RX   (RX),
        .cmd  (cmd_if)
    );

    // Pulse monitor
    int cyc;
    int n_done, n_err, n_wr, n_both, wr_cyc;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cmd_if.cmd_done) n_done++;
        if (cmd_if.cmd_error) n_err++;
        if (cmd_if.cmd_done && cmd_if.cmd_error) n_both++;
        if (cmd_if.delay_wr) begin
            n_wr++;
            wr_cyc = cyc;
        end
    end

    int n_chk, n_pass;
    int stop_cyc;
    int b_done, b_err, b_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    task automatic snap();
        b_done = n_done;
        b_err  = n_err;
        b_wr   = n_wr;
    endtask

    task automatic send_bit(input logic v);
        RX = v;
        repeat (Cpb) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        stop_cyc = cyc;
        send_bit(stop);
        if (!stop) send_bit(1'b1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural model: one complete command (opcode byte + assembled payload) at a time.
    logic [31:0] m_active, m_integ;
    int          m_idx, m_val;

    task automatic model_cmd(input logic [7:0] c, input logic [31:0] arg,
                             output int e_done, output int e_err, output int e_wr);
        int idx;
        int op;
        int v;
        idx = int'(c[7:4]);
        op  = int'(c[3:0]);
        e_done = 0;
        e_err  = 0;
        e_wr   = 0;
        if (op <= 2 && idx >= int'(NumIn)) begin
            e_err = 1;
        end else if (op == 0) begin
            m_active = m_active | (32'd1 << idx);
            e_done = 1;
        end else if (op == 1) begin
            m_active = m_active & ~(32'd1 << idx);
            e_done = 1;
        end else if (op == 2) begin
            v = int'(arg[15:0]);
            m_val = (v >= int'(MaxDly)) ? int'(MaxDly) - 1 : v;
            m_idx = idx;
            e_wr = 1;
            e_done = 1;
        end else if (op == 3) begin
            if (arg == 0) e_err = 1;
            else begin
                m_integ = arg;
                e_done = 1;
            end
        end else begin
            e_err = 1;
        end
    endtask

    typedef struct {
        int          n;
        logic [39:0] b;
        logic [31:0] active;
        logic [31:0] integ;
        int          d_done;
        int          d_err;
        int          d_wr;
        int          idx;
        int          val;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt[0]  = '{1, 40'h30,           32'h008, 32'd1000000, 1, 0, 0, 0, 0};
        vt[1]  = '{1, 40'hB0,           32'h808, 32'd1000000, 1, 0, 0, 0, 0};
        vt[2]  = '{1, 40'h31,           32'h800, 32'd1000000, 1, 0, 0, 0, 0};
        vt[3]  = '{3, 40'h01_2C_52,     32'h800, 32'd1000000, 1, 0, 1, 5, 300};
        vt[4]  = '{3, 40'hFF_FF_42,     32'h800, 32'd1000000, 1, 0, 1, 4, 1023};
        vt[5]  = '{1, 40'hC0,           32'h800, 32'd1000000, 0, 1, 0, 4, 1023};
        vt[6]  = '{3, 40'h00_01_C2,     32'h800, 32'd1000000, 0, 1, 0, 4, 1023};
        vt[7]  = '{5, 40'h00_00_00_01_33, 32'h800, 32'd1,     1, 0, 0, 4, 1023};
        vt[8]  = '{5, 40'h00_0F_42_40_03, 32'h800, 32'd1000000, 1, 0, 0, 4, 1023};
        vt[9]  = '{5, 40'h00_00_00_00_03, 32'h800, 32'd1000000, 0, 1, 0, 4, 1023};
        vt[10] = '{1, 40'h07,           32'h800, 32'd1000000, 0, 1, 0, 4, 1023};
        vt[11] = '{1, 40'hF1,           32'h800, 32'd1000000, 0, 1, 0, 4, 1023};
        vt[12] = '{3, 40'h04_00_12,     32'h800, 32'd1000000, 1, 0, 1, 1, 1023};
        vt[13] = '{3, 40'h03_FF_22,     32'h800, 32'd1000000, 1, 0, 1, 2, 1023};
        vt[14] = '{3, 40'h00_00_22,     32'h800, 32'd1000000, 1, 0, 1, 2, 0};
        vt[15] = '{1, 40'hB1,           32'h000, 32'd1000000, 1, 0, 0, 2, 0};

        reset = 1'b1;
        RX    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        settle(3);

        chk("reset active_line", cmd_if.active_line, 32'h0);
        chk("reset integration_time", cmd_if.integration_time, ClkFreq);
        chk("reset delay_wr", {31'd0, cmd_if.delay_wr}, 32'd0);
        chk("reset delay_index", {28'd0, cmd_if.delay_index}, 32'd0);
        chk("reset delay_value", {22'd0, cmd_if.delay_value}, 32'd0);
        chk("reset pulse count", n_done + n_err, 0);

        // Table-driven command vectors
        for (int r = 0; r < 16; r++) begin
            snap();
            for (int i = 0; i < vt[r].n; i++) send_byte(vt[r].b[8*i +: 8], 1'b1);
            settle(3);
            chk($sformatf("vec%0d active_line", r), cmd_if.active_line, vt[r].active);
            chk($sformatf("vec%0d integration_time", r), cmd_if.integration_time, vt[r].integ);
            chk($sformatf("vec%0d cmd_done count", r), n_done - b_done, vt[r].d_done);
            chk($sformatf("vec%0d cmd_error count", r), n_err - b_err, vt[r].d_err);
            chk($sformatf("vec%0d delay_wr count", r), n_wr - b_wr, vt[r].d_wr);
            chk($sformatf("vec%0d delay_index", r), {28'd0, cmd_if.delay_index}, vt[r].idx);
            chk($sformatf("vec%0d delay_value", r), {22'd0, cmd_if.delay_value}, vt[r].val);
        end

        // delay_wr lands one cycle after the final stop-bit centre (stop bit drive + ~11)
        snap();
        send_byte(8'h52, 1'b1);
        send_byte(8'h2C, 1'b1);
        send_byte(8'h01, 1'b1);
        settle(3);
        chk("timing delay_wr count", n_wr - b_wr, 1);
        chk_range("timing delay_wr latency", wr_cyc - stop_cyc, 10, 14);

        // Framing error mid-command: parser must drop back to idle
        snap();
        send_byte(8'h52, 1'b1);
        send_byte(8'h55, 1'b0);
        settle(3);
        chk("framing cmd_error count", n_err - b_err, 1);
        chk("framing cmd_done count", n_done - b_done, 0);
        snap();
        send_byte(8'h10, 1'b1);
        settle(3);
        chk("framing recovery bit1", cmd_if.active_line & 32'h2, 32'h2);
        chk("framing recovery done", n_done - b_done, 1);
        chk("framing recovery no delay_wr", n_wr - b_wr, 0);

        // Short low glitch must not start a byte
        snap();
        @(posedge clk);
        RX = 1'b0;
        repeat (4) @(posedge clk);
        RX = 1'b1;
        settle(200);
        chk("glitch pulses", (n_err - b_err) + (n_done - b_done), 0);
        send_byte(8'h20, 1'b1);
        settle(3);
        chk("glitch follow-on bit2", cmd_if.active_line & 32'h4, 32'h4);
        chk("glitch follow-on done", n_done - b_done, 1);
        chk("glitch follow-on error", n_err - b_err, 0);

`ifdef CMD_TIMEOUT_EN
        snap();
        send_byte(8'h52, 1'b1);
        send_byte(8'h2C, 1'b1);
        settle(590);
        chk("timeout not early", n_err - b_err, 0);
        settle(60);
        chk("timeout cmd_error", n_err - b_err, 1);
        chk("timeout no delay_wr", n_wr - b_wr, 0);
        snap();
        send_byte(8'h00, 1'b1);
        settle(3);
        chk("timeout follow-on bit0", cmd_if.active_line & 32'h1, 32'h1);
        chk("timeout follow-on done", n_done - b_done, 1);
        chk("timeout follow-on no delay_wr", n_wr - b_wr, 0);
`else
        snap();
        send_byte(8'h52, 1'b1);
        send_byte(8'h2C, 1'b1);
        settle(700);
        chk("no-timeout idle error", n_err - b_err, 0);
        send_byte(8'h01, 1'b1);
        settle(3);
        chk("no-timeout delay_wr", n_wr - b_wr, 1);
        chk("no-timeout delay_index", {28'd0, cmd_if.delay_index}, 5);
        chk("no-timeout delay_value", {22'd0, cmd_if.delay_value}, 300);
`endif

        // Reset asserted mid-byte
        snap();
        send_byte(8'h03, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        settle(3);
        chk("pre-reset integration_time", cmd_if.integration_time, 32'd5);
        @(posedge clk);
        RX = 1'b0;
        repeat (40) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midreset active_line", cmd_if.active_line, 32'h0);
        chk("midreset integration_time", cmd_if.integration_time, ClkFreq);
        chk("midreset delay_index", {28'd0, cmd_if.delay_index}, 32'd0);
        chk("midreset delay_value", {22'd0, cmd_if.delay_value}, 32'd0);
        chk("midreset pulses", {29'd0, cmd_if.delay_wr, cmd_if.cmd_done, cmd_if.cmd_error}, 32'd0);
        RX = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        snap();
        settle(200);
        chk("post-reset no pulses", (n_err - b_err) + (n_done - b_done), 0);
        send_byte(8'h00, 1'b1);
        settle(3);
        chk("post-reset active_line", cmd_if.active_line, 32'h1);
        chk("post-reset done", n_done - b_done, 1);

        // Randomized commands against the model
        m_active = 32'h1;
        m_integ  = ClkFreq;
        m_idx    = 0;
        m_val    = 0;
        for (int k = 0; k < 40; k++) begin
            logic [7:0]  c;
            logic [31:0] arg;
            int          nb, ed, ee, ew;
            c[7:4] = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1:    c[3:0] = 4'h0;
                2, 3:    c[3:0] = 4'h1;
                4, 5, 6: c[3:0] = 4'h2;
                7, 8:    c[3:0] = 4'h3;
                default: c[3:0] = 4'($urandom_range(4, 15));
            endcase
            arg = $urandom;
            nb  = 0;
            if (c[3:0] == 4'h2) begin
                nb = 2;
                if ($urandom_range(0, 1) == 1) arg = arg & 32'h0000_07FF;
            end else if (c[3:0] == 4'h3) begin
                nb = 4;
                if ($urandom_range(0, 5) == 0) arg = 32'd0;
            end
            snap();
            send_byte(c, 1'b1);
            for (int j = 0; j < nb; j++) send_byte(arg[8*j +: 8], 1'b1);
            model_cmd(c, arg, ed, ee, ew);
            settle(3);
            chk($sformatf("rnd%0d active_line", k), cmd_if.active_line, m_active);
            chk($sformatf("rnd%0d integration_time", k), cmd_if.integration_time, m_integ);
            chk($sformatf("rnd%0d cmd_done", k), n_done - b_done, ed);
            chk($sformatf("rnd%0d cmd_error", k), n_err - b_err, ee);
            chk($sformatf("rnd%0d delay_wr", k), n_wr - b_wr, ew);
            chk($sformatf("rnd%0d delay_index", k), {28'd0, cmd_if.delay_index}, m_idx);
            chk($sformatf("rnd%0d delay_value", k), {22'd0, cmd_if.delay_value}, m_val);
        end

        chk("done/error overlap cycles", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
